// File: rtl/opb_register_bank.sv
// opb_register_bank: OPB slave that exposes C_NUM_REGS 32-bit registers to user logic.
// A CTRL word follows the data registers. In shadow mode a commit write to CTRL
// loads every active register from its shadow register on the same edge.
// Ports:
//   OPB_Clk, OPB_Rst               - bus clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW/select    - OPB master request (OPB_seqAddr is ignored)
//   Sl_DBus/xferAck/errAck/retry/toutSup - slave response
//   user_data_out, user_update     - active registers and their load pulse
module opb_register_bank #(
    parameter logic [31:0] C_BASEADDR    = 32'h01000900,
    parameter logic [31:0] C_HIGHADDR    = 32'h010009FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 8,
    parameter logic [31:0] C_RESET_VALUE = 32'h0,
    parameter bit          C_SHADOW      = 1'b1,
    parameter              C_FAMILY      = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:31]             OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:31]             OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:31]             Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0] user_data_out,
    output logic                    user_update
);

    localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

    // Positional assignment turns OPB big-endian numbering into user [31:0]:
    // OPB_DBus[0] becomes bit 31, OPB_BE[0] becomes be[3].
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] diff;
    logic [31:0] word;
    logic [IW-1:0] idx;

    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;
    assign be    = OPB_BE;
    assign diff  = addr - C_BASEADDR;
    assign word  = {2'b00, diff[31:2]};
    assign idx   = word[IW-1:0];

    logic ack_q, rnw_q, data_q, ctrl_q, load_q, update_q;
    logic [IW-1:0] idx_q;
    logic [31:0] shadow_q [C_NUM_REGS];
    logic [31:0] shadow_d [C_NUM_REGS];
    logic [31:0] active_q [C_NUM_REGS];
    logic [31:0] active_d [C_NUM_REGS];
    logic [15:0] count_q, count_d;
    logic        pending_q, pending_d;

    logic in_range, hit, is_data, is_ctrl, wr_data, commit, load_d;

    assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    // The ack cycle itself never decodes, so a held select cannot double-ack.
    assign hit      = OPB_select && in_range && !ack_q;
    assign is_data  = word < 32'(C_NUM_REGS);
    assign is_ctrl  = word == 32'(C_NUM_REGS);
    assign wr_data  = hit && !OPB_RNW && is_data;
    assign commit   = hit && !OPB_RNW && is_ctrl && be[0] && wdata[0];
    assign load_d   = C_SHADOW ? commit : wr_data;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  en);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = en[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        count_d   = count_q;
        pending_d = pending_q;
        if (wr_data) begin
            if (C_SHADOW) begin
                shadow_d[idx] = merge(shadow_q[idx], wdata, be);
                pending_d     = 1'b1;
            end else begin
                active_d[idx] = merge(active_q[idx], wdata, be);
            end
        end
        if (commit) begin
            if (C_SHADOW) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ack_q     <= 1'b0;
            rnw_q     <= 1'b0;
            data_q    <= 1'b0;
            ctrl_q    <= 1'b0;
            idx_q     <= '0;
            load_q    <= 1'b0;
            update_q  <= 1'b0;
            count_q   <= 16'h0;
            pending_q <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow_q[i] <= C_RESET_VALUE;
                active_q[i] <= C_RESET_VALUE;
            end
        end else begin
            ack_q     <= hit;
            rnw_q     <= OPB_RNW;
            data_q    <= is_data;
            ctrl_q    <= is_ctrl;
            idx_q     <= idx;
            load_q    <= load_d;
            update_q  <= load_q;
            count_q   <= count_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    // Read data is muxed from live state in the ack cycle, so a CTRL read
    // always sees the post-commit value.
    logic [31:0] rdata;
    always_comb begin
        rdata = 32'h0;
        if (ack_q && rnw_q) begin
            if (data_q)
                rdata = C_SHADOW ? shadow_q[idx_q] : active_q[idx_q];
            else if (ctrl_q)
                rdata = {count_q, 15'h0, pending_q};
        end
    end

    assign Sl_DBus     = rdata;
    assign Sl_xferAck  = ack_q;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_update = update_q;

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = active_q[g];
    end

    logic unused_sig;
    assign unused_sig = ^{OPB_seqAddr, diff[1:0],
                          C_OPB_AWIDTH == 32, C_OPB_DWIDTH == 32,
                          $bits(C_FAMILY) > 0};

endmodule
